// File: rtl/ntoone_mux_seq.sv
// Purpose : registered N-to-1 channel mux, manual (S) or round-robin channel choice.
// Latency : one cycle from accept to Z/CH_ID/OUT_VALID.
// Backpressure: valid/ready skid-free; IN_READY = !OUT_VALID || OUT_READY, held word is stable.
// Ports   : CLK, RST_N (sync, active-low); D (CH channels of WIDTH), S, MODE, IN_VALID/IN_READY;
//           Z, CH_ID, OUT_VALID/OUT_READY; Z_PAR (even parity of Z) only when
//           NTOONE_MUX_PARITY_EN is defined.
module ntoone_mux_seq #(
   parameter int WIDTH = 1,
   parameter int CH    = 4,
   localparam int SEL_W = $clog2(CH)
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [CH*WIDTH-1:0] D,
   input  logic [SEL_W-1:0]    S,
   input  logic                MODE,
   input  logic                IN_VALID,
   output logic                IN_READY,
   output logic [WIDTH-1:0]    Z,
   output logic [SEL_W-1:0]    CH_ID,
   output logic                OUT_VALID,
   input  logic                OUT_READY
`ifdef NTOONE_MUX_PARITY_EN
   ,
   output logic                Z_PAR
`endif
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);

   logic [SEL_W-1:0] rr;
   logic [SEL_W-1:0] rr_nxt;
   logic [SEL_W-1:0] man_idx;
   logic [SEL_W-1:0] sel_idx;
   logic [WIDTH-1:0] sel_dat;
   logic             accept;

   // Ready is forced low in reset so nothing is accepted on a reset edge.
   assign IN_READY = RST_N && (!OUT_VALID || OUT_READY);
   assign accept   = IN_VALID && IN_READY;

   // Out-of-range manual selects (only possible when CH is not a power of
   // two) saturate to the last channel; compare one bit wider so the check
   // stays meaningful for every CH.
   always_comb begin
      man_idx = S;
      if ({1'b0, S} > {1'b0, LAST_CH}) begin
         man_idx = LAST_CH;
      end
   end

   assign sel_idx = MODE ? rr : man_idx;
   assign rr_nxt  = (rr == LAST_CH) ? '0 : rr + SEL_W'(1);

   // sel_idx is always in range, so the default is never the only match
   // except for the last channel itself.
   always_comb begin
      sel_dat = D[(CH-1)*WIDTH +: WIDTH];
      for (int k = 0; k < CH; k++) begin
         if (sel_idx == SEL_W'(k)) begin
            sel_dat = D[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         Z         <= '0;
         CH_ID     <= '0;
         OUT_VALID <= 1'b0;
         rr        <= '0;
`ifdef NTOONE_MUX_PARITY_EN
         Z_PAR     <= 1'b0;
`endif
      end else begin
         if (accept) begin
            Z         <= sel_dat;
            CH_ID     <= sel_idx;
            OUT_VALID <= 1'b1;
`ifdef NTOONE_MUX_PARITY_EN
            Z_PAR     <= ^sel_dat;
`endif
            // Pointer moves only on scan-mode accepts; manual accepts leave it.
            if (MODE) begin
               rr <= rr_nxt;
            end
         end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ntoone_mux_seq.sv
module tb_ntoone_mux_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] d;
   logic [1:0]  s;
   logic        mode;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  z;
   logic [1:0]  ch_id;
   logic        out_valid;
   logic        out_ready;

   logic [23:0] d_b;
   logic [1:0]  s_b;
   logic        in_valid_b;
   logic        in_ready_b;
   logic [7:0]  z_b;
   logic [1:0]  ch_id_b;
   logic        out_valid_b;
`ifdef NTOONE_MUX_PARITY_EN
   logic        z_par;
   logic        z_par_b;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ntoone_mux_seq #(.WIDTH(8), .CH(4)) dut (
      .CLK(clk), .RST_N(rst_n), .D(d), .S(s), .MODE(mode),
      .IN_VALID(in_valid), .IN_READY(in_ready), .Z(z), .CH_ID(ch_id),
      .OUT_VALID(out_valid), .OUT_READY(out_ready)
`ifdef NTOONE_MUX_PARITY_EN
      , .Z_PAR(z_par)
`endif
   );

   ntoone_mux_seq #(.WIDTH(8), .CH(3)) dut_b (
      .CLK(clk), .RST_N(rst_n), .D(d_b), .S(s_b), .MODE(1'b0),
      .IN_VALID(in_valid_b), .IN_READY(in_ready_b), .Z(z_b), .CH_ID(ch_id_b),
      .OUT_VALID(out_valid_b), .OUT_READY(1'b1)
`ifdef NTOONE_MUX_PARITY_EN
      , .Z_PAR(z_par_b)
`endif
   );

   typedef struct {
      logic        mode;
      logic [1:0]  s;
      logic [31:0] d;
      logic        iv;
      logic        ordy;
      logic        exp_rdy;
      logic [7:0]  exp_z;
      logic [1:0]  exp_id;
      logic        exp_ov;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic m, input logic [1:0] sel, input logic [31:0] dat,
                        input logic iv, input logic ordy);
      mode = m; s = sel; d = dat; in_valid = iv; out_ready = ordy;
   endtask

   initial begin
      // mode, s, d, iv, ordy, exp_rdy, exp_z, exp_id, exp_ov
      tbl[0]  = '{1'b0, 2'd2, 32'h44332211, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1};
      tbl[1]  = '{1'b0, 2'd0, 32'h44332211, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1};
      tbl[2]  = '{1'b0, 2'd3, 32'h44332211, 1'b1, 1'b0, 1'b0, 8'h11, 2'd0, 1'b1};
      tbl[3]  = '{1'b0, 2'd1, 32'h44332211, 1'b0, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0};
      tbl[4]  = '{1'b0, 2'd3, 32'h44332211, 1'b1, 1'b0, 1'b1, 8'h44, 2'd3, 1'b1};
      tbl[5]  = '{1'b1, 2'd3, 32'hA0B0C0D0, 1'b1, 1'b1, 1'b1, 8'hD0, 2'd0, 1'b1};
      tbl[6]  = '{1'b0, 2'd1, 32'hA0B0C0D0, 1'b1, 1'b1, 1'b1, 8'hC0, 2'd1, 1'b1};
      tbl[7]  = '{1'b1, 2'd3, 32'hA0B0C0D0, 1'b1, 1'b1, 1'b1, 8'hC0, 2'd1, 1'b1};
      tbl[8]  = '{1'b1, 2'd0, 32'h01020304, 1'b1, 1'b1, 1'b1, 8'h02, 2'd2, 1'b1};
      tbl[9]  = '{1'b1, 2'd0, 32'h01020304, 1'b0, 1'b1, 1'b1, 8'h00, 2'd0, 1'b0};
      tbl[10] = '{1'b1, 2'd0, 32'h01020304, 1'b1, 1'b1, 1'b1, 8'h01, 2'd3, 1'b1};
      tbl[11] = '{1'b1, 2'd0, 32'h01020304, 1'b1, 1'b1, 1'b1, 8'h04, 2'd0, 1'b1};

      rst_n = 1'b0;
      drive(1'b0, 2'd0, 32'h44332211, 1'b1, 1'b1);
      d_b = 24'hCCBBAA; s_b = 2'd0; in_valid_b = 1'b0;

      // Reset: ready low during reset, registers cleared.
      tick();
      check("rst_in_ready", in_ready, 1'b0);
      tick();
      check("rst_z", z, 8'h00);
      check("rst_ch_id", ch_id, 2'd0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_b_out_valid", out_valid_b, 1'b0);
      rst_n = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].mode, tbl[i].s, tbl[i].d, tbl[i].iv, tbl[i].ordy);
         #1;
         check($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].exp_rdy);
         tick();
         check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_ov);
         if (tbl[i].exp_ov) begin
            check($sformatf("tbl%0d_z", i), z, tbl[i].exp_z);
            check($sformatf("tbl%0d_ch_id", i), ch_id, tbl[i].exp_id);
         end
      end

      // Round-robin sequence right after reset.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drive(1'b1, 2'd3, 32'h44332211, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         logic [7:0] exp_z_rr;
         logic [1:0] exp_id_rr;
         exp_id_rr = 2'(i % 4);
         exp_z_rr  = 8'(8'h11 * (i % 4 + 1));
         tick();
         check($sformatf("rr%0d_ch_id", i), ch_id, exp_id_rr);
         check($sformatf("rr%0d_z", i), z, exp_z_rr);
         check($sformatf("rr%0d_out_valid", i), out_valid, 1'b1);
      end

      // Backpressure: held word (z=22, id=1) stays put while inputs churn.
      for (int i = 0; i < 3; i++) begin
         drive(i[0], 2'(i), 32'hDEAD0000 + i, 1'b1, 1'b0);
         #1;
         check($sformatf("bp%0d_in_ready", i), in_ready, 1'b0);
         tick();
         check($sformatf("bp%0d_z", i), z, 8'h22);
         check($sformatf("bp%0d_ch_id", i), ch_id, 2'd1);
         check($sformatf("bp%0d_out_valid", i), out_valid, 1'b1);
      end
      drive(1'b0, 2'd0, 32'h44332211, 1'b0, 1'b1);
      #1;
      check("drain_in_ready", in_ready, 1'b1);
      tick();
      check("drain_out_valid", out_valid, 1'b0);

      // Reset mid-transfer with rr=2: load via manual mode so rr is untouched.
      drive(1'b0, 2'd3, 32'h44332211, 1'b1, 1'b0);
      tick();
      check("pre_rst_z", z, 8'h44);
      rst_n = 1'b0;
      drive(1'b1, 2'd0, 32'h44332211, 1'b1, 1'b1);
      #1;
      check("mid_rst_in_ready", in_ready, 1'b0);
      tick();
      check("mid_rst_z", z, 8'h00);
      check("mid_rst_ch_id", ch_id, 2'd0);
      check("mid_rst_out_valid", out_valid, 1'b0);
      rst_n = 1'b1;
      tick();
      check("post_rst_ch_id", ch_id, 2'd0);
      check("post_rst_z", z, 8'h11);
      check("post_rst_out_valid", out_valid, 1'b1);

      // CH=3 instance: out-of-range select saturates to channel 2.
      s_b = 2'd3; in_valid_b = 1'b1;
      tick();
      check("ch3_sat_ch_id", ch_id_b, 2'd2);
      check("ch3_sat_z", z_b, 8'hCC);
      s_b = 2'd1;
      tick();
      check("ch3_s1_ch_id", ch_id_b, 2'd1);
      check("ch3_s1_z", z_b, 8'hBB);
      in_valid_b = 1'b0;

`ifdef NTOONE_MUX_PARITY_EN
      drive(1'b0, 2'd0, 32'h00000007, 1'b1, 1'b1);
      tick();
      check("par_07", z_par, 1'b1);
      drive(1'b0, 2'd0, 32'h00000003, 1'b1, 1'b1);
      tick();
      check("par_03", z_par, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
